// File: rtl/addr_window_cfg_bank_if.sv
// Byte-wide configuration bus for the address-window configuration bank.
// The master drives the strobes, address and write data. The slave returns registered read data.
interface addr_window_cfg_bank_if #(
  parameter int CFG_AW = 8
) ();
  logic              cfg_we;
  logic              cfg_re;
  logic [CFG_AW-1:0] cfg_addr;
  logic [7:0]        cfg_wdata;
  logic [7:0]        cfg_rdata;
  logic              cfg_rvalid;

  modport master (
    output cfg_we, cfg_re, cfg_addr, cfg_wdata,
    input  cfg_rdata, cfg_rvalid
  );

  modport slave (
    input  cfg_we, cfg_re, cfg_addr, cfg_wdata,
    output cfg_rdata, cfg_rvalid
  );
endinterface

// File: rtl/addr_window_cfg_bank.sv
// Double-buffered BASE/MASK/SLOT/ENABLE/OP window tables for the Dock address decoder.
// A byte-addressed shadow copy is copied into the active copy in a single step, and only while the decoder is idle.
module addr_window_cfg_bank #(
  parameter int ADDR_W  = 32,
  parameter int NUM_WIN = 16,
  parameter int SLOT_W  = 3,
  parameter int CFG_AW  = 8
) (
  input  logic                        cfg_clk,
  input  logic                        rst_n,
  addr_window_cfg_bank_if.slave       cfg,
  input  logic                        dec_idle,
  output logic                        cfg_busy,
  output logic                        commit_done,
  output logic [NUM_WIN*ADDR_W-1:0]   base_flat,
  output logic [NUM_WIN*ADDR_W-1:0]   mask_flat,
  output logic [NUM_WIN*SLOT_W-1:0]   slot_flat,
  output logic [NUM_WIN-1:0]          en_flat,
  output logic [NUM_WIN*8-1:0]        op_flat
);
  localparam int CB       = (ADDR_W + 7) / 8;
  localparam int MASK_OFF = NUM_WIN * CB;
  localparam int SLOT_OFF = 2 * NUM_WIN * CB;
  localparam int OP_OFF   = SLOT_OFF + NUM_WIN;
  localparam int CTRL_OFF = OP_OFF + NUM_WIN;
  localparam int STAT_OFF = CTRL_OFF + 1;
  localparam int WIN_W    = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int BYTE_W   = (CB > 1) ? $clog2(CB) : 1;

  localparam logic [CFG_AW-1:0] A_CB   = CFG_AW'(CB);
  localparam logic [CFG_AW-1:0] A_MASK = CFG_AW'(MASK_OFF);
  localparam logic [CFG_AW-1:0] A_SLOT = CFG_AW'(SLOT_OFF);
  localparam logic [CFG_AW-1:0] A_OP   = CFG_AW'(OP_OFF);
  localparam logic [CFG_AW-1:0] A_CTRL = CFG_AW'(CTRL_OFF);
  localparam logic [CFG_AW-1:0] A_STAT = CFG_AW'(STAT_OFF);

  typedef enum logic [2:0] {R_BASE, R_MASK, R_SLOT, R_OP, R_CTRL, R_STAT, R_OOR} region_e;
  typedef enum logic {ST_IDLE, ST_PENDING} state_e;

  // Byte b of a word. Bits above ADDR_W come back as zero because the shift fills them with zero.
  function automatic logic [7:0] word_byte(input logic [ADDR_W-1:0] word, input logic [BYTE_W-1:0] b);
    logic [ADDR_W-1:0] sh;
    sh = word >> {b, 3'b000};
    return sh[7:0];
  endfunction

  // Replace byte b of a word. Data bits that fall above ADDR_W are truncated away.
  function automatic logic [ADDR_W-1:0] put_byte(input logic [ADDR_W-1:0] word,
                                                  input logic [BYTE_W-1:0] b,
                                                  input logic [7:0]        data);
    logic [ADDR_W+7:0] m;
    logic [ADDR_W+7:0] d;
    m = {{ADDR_W{1'b0}}, 8'hFF} << {b, 3'b000};
    d = {{ADDR_W{1'b0}}, data} << {b, 3'b000};
    return (word & ~m[ADDR_W-1:0]) | d[ADDR_W-1:0];
  endfunction

  function automatic logic [7:0] slot_byte(input logic en, input logic [SLOT_W-1:0] slot);
    logic [7:0] r;
    r             = 8'h00;
    r[SLOT_W-1:0] = slot;
    r[7]          = en;
    return r;
  endfunction

  logic [ADDR_W-1:0] base_sh_r [NUM_WIN];
  logic [ADDR_W-1:0] mask_sh_r [NUM_WIN];
  logic [SLOT_W-1:0] slot_sh_r [NUM_WIN];
  logic [7:0]        op_sh_r   [NUM_WIN];
  logic [NUM_WIN-1:0] en_sh_r;
  logic [ADDR_W-1:0] base_ac_r [NUM_WIN];
  logic [ADDR_W-1:0] mask_ac_r [NUM_WIN];
  logic [SLOT_W-1:0] slot_ac_r [NUM_WIN];
  logic [7:0]        op_ac_r   [NUM_WIN];
  logic [NUM_WIN-1:0] en_ac_r;

  state_e      state_r;
  logic        busy_r, done_r, dirty_r, err_r, view_r, rvalid_r;
  logic [7:0]  rdata_r;

  region_e           region_s;
  logic [CFG_AW-1:0] off_s;
  logic [WIN_W-1:0]  win_s;
  logic [BYTE_W-1:0] byte_s;
  logic [7:0]        rd_byte_s;
  logic              data_wr_s, shadow_wr_s, ctrl_wr_s;
  logic              revert_s, commit_s, clr_s, err_evt_s, apply_s;

  // Address decode: region, window index and byte-within-word.
  always_comb begin
    region_s = R_OOR;
    off_s    = '0;
    win_s    = '0;
    byte_s   = '0;
    if (cfg.cfg_addr < A_MASK) begin
      region_s = R_BASE;
      off_s    = cfg.cfg_addr;
    end else if (cfg.cfg_addr < A_SLOT) begin
      region_s = R_MASK;
      off_s    = cfg.cfg_addr - A_MASK;
    end else if (cfg.cfg_addr < A_OP) begin
      region_s = R_SLOT;
      off_s    = cfg.cfg_addr - A_SLOT;
    end else if (cfg.cfg_addr < A_CTRL) begin
      region_s = R_OP;
      off_s    = cfg.cfg_addr - A_OP;
    end else if (cfg.cfg_addr == A_CTRL) begin
      region_s = R_CTRL;
    end else if (cfg.cfg_addr == A_STAT) begin
      region_s = R_STAT;
    end else begin
      region_s = R_OOR;
    end
    if ((region_s == R_BASE) || (region_s == R_MASK)) begin
      win_s  = WIN_W'(off_s / A_CB);
      byte_s = BYTE_W'(off_s % A_CB);
    end else begin
      win_s  = WIN_W'(off_s);
      byte_s = '0;
    end
  end

  // Control decode. REVERT overrides COMMIT. A commit in flight is abandoned if REVERT arrives on the same edge.
  always_comb begin
    data_wr_s   = cfg.cfg_we && ((region_s == R_BASE) || (region_s == R_MASK) ||
                                 (region_s == R_SLOT) || (region_s == R_OP));
    shadow_wr_s = data_wr_s && (state_r == ST_IDLE);
    ctrl_wr_s   = cfg.cfg_we && (region_s == R_CTRL);
    revert_s    = ctrl_wr_s && cfg.cfg_wdata[1];
    commit_s    = ctrl_wr_s && cfg.cfg_wdata[0] && !cfg.cfg_wdata[1];
    clr_s       = ctrl_wr_s && cfg.cfg_wdata[2];
    err_evt_s   = ((cfg.cfg_we || cfg.cfg_re) && (region_s == R_OOR)) ||
                  (data_wr_s && (state_r == ST_PENDING));
    apply_s     = (state_r == ST_PENDING) && dec_idle && !revert_s;
  end

  // Read mux over shadow or active copy (VIEW), plus CTRL and STATUS.
  always_comb begin
    rd_byte_s = 8'h00;
    case (region_s)
      R_BASE:  rd_byte_s = word_byte(view_r ? base_ac_r[win_s] : base_sh_r[win_s], byte_s);
      R_MASK:  rd_byte_s = word_byte(view_r ? mask_ac_r[win_s] : mask_sh_r[win_s], byte_s);
      R_SLOT:  rd_byte_s = view_r ? slot_byte(en_ac_r[win_s], slot_ac_r[win_s])
                                  : slot_byte(en_sh_r[win_s], slot_sh_r[win_s]);
      R_OP:    rd_byte_s = view_r ? op_ac_r[win_s] : op_sh_r[win_s];
      R_CTRL:  rd_byte_s = {4'b0000, view_r, 3'b000};
      R_STAT:  rd_byte_s = {5'b00000, dirty_r, err_r, (state_r == ST_PENDING)};
      default: rd_byte_s = 8'h00;
    endcase
  end

  // Commit FSM with its status flags and registered handshake outputs.
  always_ff @(posedge cfg_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dirty_r <= 1'b0;
      err_r   <= 1'b0;
      view_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (commit_s) begin
            state_r <= ST_PENDING;
            busy_r  <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (revert_s || dec_idle) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      done_r <= apply_s;
      if (revert_s || apply_s) begin
        dirty_r <= 1'b0;
      end else if (shadow_wr_s) begin
        dirty_r <= 1'b1;
      end
      err_r <= (err_r && !clr_s) || err_evt_s;
      if (ctrl_wr_s) begin
        view_r <= cfg.cfg_wdata[3];
      end
    end
  end

  // Shadow tables: byte writes while idle, or reload from active on REVERT.
  always_ff @(posedge cfg_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        base_sh_r[w] <= '0;
        mask_sh_r[w] <= '0;
        slot_sh_r[w] <= '0;
        op_sh_r[w]   <= 8'hFF;
      end
      en_sh_r <= '0;
    end else if (revert_s) begin
      base_sh_r <= base_ac_r;
      mask_sh_r <= mask_ac_r;
      slot_sh_r <= slot_ac_r;
      op_sh_r   <= op_ac_r;
      en_sh_r   <= en_ac_r;
    end else if (shadow_wr_s) begin
      case (region_s)
        R_BASE:  base_sh_r[win_s] <= put_byte(base_sh_r[win_s], byte_s, cfg.cfg_wdata);
        R_MASK:  mask_sh_r[win_s] <= put_byte(mask_sh_r[win_s], byte_s, cfg.cfg_wdata);
        R_SLOT: begin
          slot_sh_r[win_s] <= cfg.cfg_wdata[SLOT_W-1:0];
          en_sh_r[win_s]   <= cfg.cfg_wdata[7];
        end
        R_OP:    op_sh_r[win_s] <= cfg.cfg_wdata;
        default: ;
      endcase
    end
  end

  // Active tables: the whole shadow is copied at the commit edge, so the decoder never sees a partial update.
  always_ff @(posedge cfg_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        base_ac_r[w] <= '0;
        mask_ac_r[w] <= '0;
        slot_ac_r[w] <= '0;
        op_ac_r[w]   <= 8'hFF;
      end
      en_ac_r <= '0;
    end else if (apply_s) begin
      base_ac_r <= base_sh_r;
      mask_ac_r <= mask_sh_r;
      slot_ac_r <= slot_sh_r;
      op_ac_r   <= op_sh_r;
      en_ac_r   <= en_sh_r;
    end
  end

  // Registered read port. The data holds between reads.
  always_ff @(posedge cfg_clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r  <= 8'h00;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= cfg.cfg_re;
      if (cfg.cfg_re) begin
        rdata_r <= rd_byte_s;
      end
    end
  end

  assign cfg.cfg_rdata  = rdata_r;
  assign cfg.cfg_rvalid = rvalid_r;
  assign cfg_busy       = busy_r;
  assign commit_done    = done_r;
  assign en_flat        = en_ac_r;

  for (genvar w = 0; w < NUM_WIN; w++) begin : g_flat
    assign base_flat[w*ADDR_W +: ADDR_W] = base_ac_r[w];
    assign mask_flat[w*ADDR_W +: ADDR_W] = mask_ac_r[w];
    assign slot_flat[w*SLOT_W +: SLOT_W] = slot_ac_r[w];
    assign op_flat[w*8 +: 8]             = op_ac_r[w];
  end
endmodule

// File: tb/tb_addr_window_cfg_bank.sv
// Bench for addr_window_cfg_bank: directed scenarios followed by random traffic.
// Every cycle is checked against a reference model that treats the configuration space as a flat byte array.
module tb_addr_window_cfg_bank;
  localparam int ADDR_W = 32, NUM_WIN = 16, SLOT_W = 3, CFG_AW = 8;
  localparam int CB = 4, MASK_OFF = 64, SLOT_OFF = 128, OP_OFF = 144;
  localparam int CTRL_OFF = 160, STAT_OFF = 161;

  logic cfg_clk  = 1'b0;
  logic rst_n    = 1'b1;
  logic dec_idle = 1'b0;
  logic cfg_busy, commit_done;
  logic [NUM_WIN*ADDR_W-1:0] base_flat, mask_flat;
  logic [NUM_WIN*SLOT_W-1:0] slot_flat;
  logic [NUM_WIN-1:0]        en_flat;
  logic [NUM_WIN*8-1:0]      op_flat;

  addr_window_cfg_bank_if #(.CFG_AW(CFG_AW)) cfg_bus ();

  addr_window_cfg_bank #(.ADDR_W(ADDR_W), .NUM_WIN(NUM_WIN), .SLOT_W(SLOT_W), .CFG_AW(CFG_AW)) dut (
    .cfg_clk(cfg_clk), .rst_n(rst_n), .cfg(cfg_bus.slave), .dec_idle(dec_idle),
    .cfg_busy(cfg_busy), .commit_done(commit_done), .base_flat(base_flat), .mask_flat(mask_flat),
    .slot_flat(slot_flat), .en_flat(en_flat), .op_flat(op_flat)
  );

  always #5 cfg_clk = ~cfg_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the shadow and active copies are plain byte images of the data region.
  logic [7:0] m_sh [0:CTRL_OFF-1];
  logic [7:0] m_ac [0:CTRL_OFF-1];
  logic       m_pend, m_err, m_dirty, m_view;
  logic [7:0] m_rd;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int a = 0; a < CTRL_OFF; a++) begin
      m_sh[a] = (a >= OP_OFF) ? 8'hFF : 8'h00;
      m_ac[a] = m_sh[a];
    end
    m_pend = 1'b0; m_err = 1'b0; m_dirty = 1'b0; m_view = 1'b0; m_rd = 8'h00;
  endtask

  function automatic logic [7:0] m_read(input int addr);
    if (addr > STAT_OFF)       return 8'h00;
    else if (addr == STAT_OFF) return {5'b00000, m_dirty, m_err, m_pend};
    else if (addr == CTRL_OFF) return {4'b0000, m_view, 3'b000};
    else                       return m_view ? m_ac[addr] : m_sh[addr];
  endfunction

  task automatic check_outputs();
    logic [NUM_WIN*ADDR_W-1:0] eb, em;
    logic [NUM_WIN*SLOT_W-1:0] es;
    logic [NUM_WIN-1:0]        ee;
    logic [NUM_WIN*8-1:0]      eo;
    for (int w = 0; w < NUM_WIN; w++) begin
      for (int b = 0; b < CB; b++) begin
        eb[w*ADDR_W + b*8 +: 8] = m_ac[w*CB + b];
        em[w*ADDR_W + b*8 +: 8] = m_ac[MASK_OFF + w*CB + b];
      end
      es[w*SLOT_W +: SLOT_W] = m_ac[SLOT_OFF + w][SLOT_W-1:0];
      ee[w]                  = m_ac[SLOT_OFF + w][7];
      eo[w*8 +: 8]           = m_ac[OP_OFF + w];
    end
    chk("base_flat", base_flat, eb);
    chk("mask_flat", mask_flat, em);
    chk("slot_flat", slot_flat, es);
    chk("en_flat", en_flat, ee);
    chk("op_flat", op_flat, eo);
  endtask

  // One clock edge with the given bus activity. The model is advanced and all outputs are compared.
  task automatic step(input bit we, input bit re, input int addr, input logic [7:0] d, input bit idle);
    logic [7:0] exp_rd;
    bit pend0, rev, apply, clr, evt;
    exp_rd = m_read(addr);
    pend0  = m_pend;
    rev    = we && (addr == CTRL_OFF) && d[1];
    apply  = pend0 && idle && !rev;
    clr    = we && (addr == CTRL_OFF) && d[2];
    evt    = 1'b0;
    cfg_bus.cfg_we    = we;
    cfg_bus.cfg_re    = re;
    cfg_bus.cfg_addr  = CFG_AW'(addr);
    cfg_bus.cfg_wdata = d;
    dec_idle          = idle;
    @(posedge cfg_clk);
    #1;
    cfg_bus.cfg_we = 1'b0;
    cfg_bus.cfg_re = 1'b0;
    if (re) begin
      m_rd = exp_rd;
      if (addr > STAT_OFF) evt = 1'b1;
    end
    if (we) begin
      if (addr > STAT_OFF) begin
        evt = 1'b1;
      end else if (addr < CTRL_OFF) begin
        if (pend0) evt = 1'b1;
        else begin
          m_sh[addr] = (addr >= SLOT_OFF && addr < OP_OFF) ? (d & 8'h87) : d;
          m_dirty    = 1'b1;
        end
      end else if (addr == CTRL_OFF) begin
        m_view = d[3];
        if (d[1]) begin
          m_sh = m_ac; m_dirty = 1'b0; m_pend = 1'b0;
        end else if (d[0] && !pend0) begin
          m_pend = 1'b1;
        end
      end
    end
    m_err = (m_err && !clr) || evt;
    if (apply) begin
      m_ac = m_sh; m_dirty = 1'b0; m_pend = 1'b0;
    end
    chk("rvalid", cfg_bus.cfg_rvalid, re);
    chk("rdata", cfg_bus.cfg_rdata, m_rd);
    chk("commit_done", commit_done, apply);
    chk("cfg_busy", cfg_busy, m_pend);
    check_outputs();
  endtask

  task automatic wr(input int addr, input logic [7:0] d, input bit idle);
    step(1'b1, 1'b0, addr, d, idle);
  endtask

  task automatic rd(input int addr, input bit idle);
    step(1'b0, 1'b1, addr, 8'h00, idle);
  endtask

  initial begin
    int r, a;
    bit idl;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_re = 1'b0;
    cfg_bus.cfg_addr = '0; cfg_bus.cfg_wdata = 8'h00;
    m_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge cfg_clk);
    #1;
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_done", commit_done, 1'b0);
    chk("rst_rvalid", cfg_bus.cfg_rvalid, 1'b0);
    check_outputs();
    @(negedge cfg_clk);
    rst_n = 1'b1;
    @(posedge cfg_clk);
    #1;

    rd(STAT_OFF, 1'b1);
    chk("stat_after_reset", cfg_bus.cfg_rdata, 8'h00);
    rd(OP_OFF + 5, 1'b1);
    chk("op5_after_reset", cfg_bus.cfg_rdata, 8'hFF);

    wr(8, 8'h78, 1'b1); wr(9, 8'h56, 1'b1); wr(10, 8'h34, 1'b1); wr(11, 8'h12, 1'b1);
    wr(SLOT_OFF + 2, 8'h85, 1'b1);
    rd(STAT_OFF, 1'b1);
    chk("stat_dirty", cfg_bus.cfg_rdata, 8'h04);
    wr(CTRL_OFF, 8'h01, 1'b1);
    step(1'b0, 1'b0, 0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 0, 8'h00, 1'b1);
    chk("base_w2", base_flat[2*ADDR_W +: ADDR_W], 32'h12345678);
    chk("slot_w2", slot_flat[2*SLOT_W +: SLOT_W], 3'd5);
    chk("en_w2", en_flat[2], 1'b1);
    rd(STAT_OFF, 1'b1);
    chk("stat_after_commit", cfg_bus.cfg_rdata, 8'h00);

    wr(CTRL_OFF, 8'h01, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, 8'h00, 1'b0);
    wr(MASK_OFF + 8, 8'hF0, 1'b0);
    rd(STAT_OFF, 1'b0);
    chk("stat_pend_err", cfg_bus.cfg_rdata, 8'h03);
    step(1'b0, 1'b0, 0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 0, 8'h00, 1'b1);
    wr(CTRL_OFF, 8'h04, 1'b1);
    rd(STAT_OFF, 1'b1);
    chk("stat_clr", cfg_bus.cfg_rdata, 8'h00);

    wr(OP_OFF, 8'hAA, 1'b1);
    wr(CTRL_OFF, 8'h02, 1'b1);
    rd(OP_OFF, 1'b1);
    chk("op0_reverted", cfg_bus.cfg_rdata, 8'hFF);
    rd(STAT_OFF, 1'b1);
    wr(OP_OFF + 1, 8'h11, 1'b1);
    wr(CTRL_OFF, 8'h03, 1'b1);
    step(1'b0, 1'b0, 0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 0, 8'h00, 1'b1);

    rd(STAT_OFF + 1, 1'b1);
    chk("oor_rdata", cfg_bus.cfg_rdata, 8'h00);
    rd(STAT_OFF, 1'b1);
    chk("oor_err", cfg_bus.cfg_rdata[1], 1'b1);
    wr(0, 8'h5A, 1'b1);
    wr(CTRL_OFF, 8'h08, 1'b1);
    rd(0, 1'b1);
    chk("view_active", cfg_bus.cfg_rdata, 8'h00);
    rd(CTRL_OFF, 1'b1);
    chk("ctrl_view", cfg_bus.cfg_rdata, 8'h08);
    wr(CTRL_OFF, 8'h04, 1'b1);
    rd(0, 1'b1);
    chk("view_shadow", cfg_bus.cfg_rdata, 8'h5A);

    for (int i = 0; i < 600; i++) begin
      r   = int'($urandom_range(0, 99));
      idl = ($urandom_range(0, 3) != 0);
      if (r < 45) begin
        a = int'($urandom_range(0, CTRL_OFF - 1));
        step(1'b1, ($urandom_range(0, 4) == 0), a, 8'($urandom), idl);
      end else if (r < 55) begin
        wr(CTRL_OFF, 8'($urandom_range(0, 15)), idl);
      end else if (r < 60) begin
        a = int'($urandom_range(STAT_OFF + 1, 170));
        step(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), a, 8'($urandom), idl);
      end else if (r < 90) begin
        rd(int'($urandom_range(0, STAT_OFF)), idl);
      end else begin
        step(1'b0, 1'b0, 0, 8'h00, idl);
      end
    end

    wr(CTRL_OFF, 8'h02, 1'b1);
    wr(4, 8'hC3, 1'b1);
    wr(CTRL_OFF, 8'h01, 1'b0);
    step(1'b0, 1'b0, 0, 8'h00, 1'b0);
    chk("busy_before_rst", cfg_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_busy_async", cfg_busy, 1'b0);
    chk("rst_done_async", commit_done, 1'b0);
    check_outputs();
    dec_idle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge cfg_clk);
      #1;
      chk("rst_no_done", commit_done, 1'b0);
    end
    @(negedge cfg_clk);
    rst_n = 1'b1;
    @(posedge cfg_clk);
    #1;
    check_outputs();
    rd(STAT_OFF, 1'b1);
    chk("stat_after_rst", cfg_bus.cfg_rdata, 8'h00);
    rd(4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
